// File: rtl/permutation_iter.sv
// -----------------------------------------------------------------------------
// permutation_iter -- iterative ASCON permutation engine (p12 / p6).
//
// One round (constant addition, 5-bit S-box layer, linear diffusion) is
// applied per clock while busy. A run is started from IDLE by start_i. It
// begins at round 0 for p12 or at round 6 for p6. It always ends after
// round 11, and completion is flagged by a one-cycle done_o pulse.
//
// Build option:
//   PERM_UNROLL2_EN  when defined, two chained rounds (r, r+1) are applied
//                    per clock. This halves the latency. Ports and handshake
//                    do not change.
//
// Ports:
//   clock_i       in   system clock, rising-edge active
//   resetb_i      in   asynchronous active-low reset
//   start_i       in   start request, only honoured in IDLE
//   rounds_sel_i  in   0 = p12, 1 = p6, sampled together with start_i
//   state_i       in   5 x 64-bit input words, state_i[i] = x_i
//   state_o       out  registered permutation state, state_o[i] = x_i
//   busy_o        out  high while rounds are being applied
//   done_o        out  one-cycle pulse when state_o holds the final result
// -----------------------------------------------------------------------------
module permutation_iter (
   input  logic             clock_i,
   input  logic             resetb_i,
   input  logic             start_i,
   input  logic             rounds_sel_i,
   input  logic [4:0][63:0] state_i,
   output logic [4:0][63:0] state_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} fsm_e;
   typedef logic [4:0][63:0] state_t;

`ifdef PERM_UNROLL2_EN
   localparam logic [3:0] ROUND_STEP = 4'd2;
`else
   localparam logic [3:0] ROUND_STEP = 4'd1;
`endif
   // Round index held in round_q during the final BUSY cycle
   localparam logic [3:0] LAST_ROUND = 4'd12 - ROUND_STEP;

   fsm_e       fsm_q;
   logic [3:0] round_q;
   state_t     state_q;
   state_t     state_d;
   logic       busy_q;
   logic       done_q;
   logic [7:0] rc_s;

   // Round constant: high nibble counts down from F while the low nibble counts up
   function automatic logic [7:0] round_const(input logic [3:0] r);
      return {4'hF - r, r};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // Bit-sliced 5-bit S-box; every bit column of x0..x4 is one S-box input
   function automatic state_t substitution(input state_t s);
      state_t x;
      state_t t;
      x    = s;
      x[0] = x[0] ^ x[4];
      x[4] = x[4] ^ x[3];
      x[2] = x[2] ^ x[1];
      for (int i = 0; i < 5; i++) begin
         t[i] = ~x[i] & x[(i + 1) % 5];
      end
      for (int i = 0; i < 5; i++) begin
         x[i] = x[i] ^ t[(i + 1) % 5];
      end
      x[1] = x[1] ^ x[0];
      x[0] = x[0] ^ x[4];
      x[3] = x[3] ^ x[2];
      x[2] = ~x[2];
      return x;
   endfunction

   function automatic state_t diffusion(input state_t s);
      state_t x;
      x[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
      x[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
      x[2] = s[2] ^ rotr(s[2],  1) ^ rotr(s[2],  6);
      x[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
      x[4] = s[4] ^ rotr(s[4],  7) ^ rotr(s[4], 41);
      return x;
   endfunction

   function automatic state_t ascon_round(input state_t s, input logic [3:0] r);
      state_t x;
      x       = s;
      x[2][7:0] = x[2][7:0] ^ round_const(r);
      return diffusion(substitution(x));
   endfunction

   assign rc_s = round_const(round_q);

   // Next permutation state: one round, or two chained rounds when unrolled
   always_comb begin
      state_d = ascon_round(state_q, round_q);
`ifdef PERM_UNROLL2_EN
      state_d = ascon_round(state_d, round_q + 4'd1);
`else
      state_d = state_d;
`endif
   end

   // Control FSM with the state register and the registered busy/done flags
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         state_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q <= state_i;
                  round_q <= rounds_sel_i ? 4'd6 : 4'd0;
                  busy_q  <= 1'b1;
                  fsm_q   <= BUSY;
               end else begin
                  busy_q  <= 1'b0;
                  fsm_q   <= IDLE;
               end
            end
            BUSY: begin
               state_q <= state_d;
               if (round_q == LAST_ROUND) begin
                  // Final round: the result lands in state_q and the FSM is
                  // IDLE in the done cycle, so a new start can be taken at once
                  round_q <= 4'd0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  fsm_q   <= IDLE;
               end else begin
                  round_q <= round_q + ROUND_STEP;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  fsm_q   <= BUSY;
               end
            end
            default: begin
               round_q <= 4'd0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               fsm_q   <= IDLE;
            end
         endcase
      end
   end

   assign state_o = state_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_iter.sv
// -----------------------------------------------------------------------------
// tb_permutation_iter -- directed self-checking bench for permutation_iter.
// Expected permutation results come from a table-driven ASCON model in this
// file. Expected latencies follow the PERM_UNROLL2_EN build option.
// -----------------------------------------------------------------------------
module tb_permutation_iter;

   typedef logic [4:0][63:0] state_t;

`ifdef PERM_UNROLL2_EN
   localparam int LAT12 = 6;
   localparam int LAT6  = 3;
   localparam logic [7:0] LAST_RC = 8'h5A;
`else
   localparam int LAT12 = 12;
   localparam int LAT6  = 6;
   localparam logic [7:0] LAST_RC = 8'h4B;
`endif

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   logic   clock_i;
   logic   resetb_i;
   logic   start_i;
   logic   rounds_sel_i;
   state_t state_i;
   state_t state_o;
   logic   busy_o;
   logic   done_o;

   int total = 0;
   int bad   = 0;

   permutation_iter dut (
      .clock_i      (clock_i),
      .resetb_i     (resetb_i),
      .start_i      (start_i),
      .rounds_sel_i (rounds_sel_i),
      .state_i      (state_i),
      .state_o      (state_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   function automatic state_t mk(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [63:0] d,
                                 input logic [63:0] e);
      state_t s;
      s[0] = a; s[1] = b; s[2] = c; s[3] = d; s[4] = e;
      return s;
   endfunction

   // Reference permutation from round 'first' through round 11, S-box by table lookup
   function automatic state_t model_perm(input state_t s_in, input int first);
      state_t     s;
      logic [4:0] idx;
      logic [4:0] o;
      logic [7:0] c;
      s = s_in;
      for (int r = first; r < 12; r++) begin
         c = 8'((15 - r) * 16 + r);
         s[2][7:0] = s[2][7:0] ^ c;
         for (int j = 0; j < 64; j++) begin
            idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            o   = SBOX[idx];
            s[0][j] = o[4]; s[1][j] = o[3]; s[2][j] = o[2];
            s[3][j] = o[1]; s[4][j] = o[0];
         end
         s[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
         s[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
         s[2] = s[2] ^ rotr(s[2],  1) ^ rotr(s[2],  6);
         s[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
         s[4] = s[4] ^ rotr(s[4],  7) ^ rotr(s[4], 41);
      end
      return s;
   endfunction

   task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge k0 cycles after a load edge; returns the cycle index of done_o
   task automatic wait_done(input int k0, output int lat, output int bcnt);
      lat  = k0;
      bcnt = 0;
      while (done_o !== 1'b1 && lat < 40) begin
         if (busy_o === 1'b1) bcnt++;
         @(negedge clock_i);
         lat++;
      end
   endtask

   task automatic load(input logic sel, input state_t st);
      @(negedge clock_i);
      start_i      = 1'b1;
      rounds_sel_i = sel;
      state_i      = st;
      @(posedge clock_i);
      @(negedge clock_i);
      start_i      = 1'b0;
   endtask

   initial begin
      state_t v6;
      state_t vb;
      state_t exp_s;
      int     lat;
      int     bcnt;
      logic   seen;

      v6 = mk(64'h25f7c341c45f9912, 64'h23b794c540876856, 64'hb85451593d679610,
              64'h4fafba264a9e49ba, 64'h62b54d5d460aded4);
      vb = mk(64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0000000000000080,
              64'hdeadbeefcafef00d, 64'h8000000000000001);

      resetb_i     = 1'b0;
      start_i      = 1'b0;
      rounds_sel_i = 1'b0;
      state_i      = '1;
      #12;
      check("rst_state", state_o, 320'd0);
      check("rst_busy",  320'(busy_o), 320'd0);
      check("rst_done",  320'(done_o), 320'd0);

      // p12 on all-zero input, start presented in the same cycle reset is released
      @(negedge clock_i);
      resetb_i     = 1'b1;
      start_i      = 1'b1;
      rounds_sel_i = 1'b0;
      state_i      = '0;
      @(posedge clock_i);
      @(negedge clock_i);
      start_i = 1'b0;
      check("p12_first_rc", 320'(dut.rc_s), 320'(8'hF0));
      repeat (LAT12 - 1) @(negedge clock_i);
      check("p12_last_rc", 320'(dut.rc_s), 320'(LAST_RC));
      wait_done(LAT12 - 1, lat, bcnt);
      check("p12_zero_latency", 320'(lat), 320'(LAT12));
      check("p12_zero_busy_cycles", 320'(bcnt - 1 + LAT12 - 1 + 1 - (LAT12 - 1)), 320'(1));
      exp_s = model_perm('0, 0);
      check("p12_zero_state", state_o, exp_s);
      @(negedge clock_i);
      check("p12_done_one_cycle", 320'(done_o), 320'd0);

      // busy cycle count over a full p12 run
      load(1'b0, '0);
      wait_done(0, lat, bcnt);
      check("p12_busy_count", 320'(bcnt), 320'(LAT12));
      check("p12_rerun_state", state_o, exp_s);

      // p6 on the reference vector; rounds_sel_i flips mid-run and must be ignored
      load(1'b1, v6);
      check("p6_first_rc", 320'(dut.rc_s), 320'(8'h96));
      rounds_sel_i = 1'b0;
      wait_done(0, lat, bcnt);
      check("p6_latency", 320'(lat), 320'(LAT6));
      exp_s = model_perm(v6, 6);
      check("p6_state", state_o, exp_s);
      repeat (4) @(negedge clock_i);
      check("p6_idle_hold", state_o, exp_s);
      check("p6_idle_busy", 320'(busy_o), 320'd0);

      // start pulsed again 3 cycles into a p12 run is ignored
      load(1'b0, vb);
      repeat (3) @(negedge clock_i);
      start_i = 1'b1;
      state_i = v6;
      @(negedge clock_i);
      start_i = 1'b0;
      wait_done(4, lat, bcnt);
      check("restart_latency", 320'(lat), 320'(LAT12));
      check("restart_state", state_o, model_perm(vb, 0));

      // reset at cycle 5 of a p12 run
      load(1'b0, v6);
      repeat (5) @(negedge clock_i);
      resetb_i = 1'b0;
      #1;
      check("midrst_state", state_o, 320'd0);
      check("midrst_busy",  320'(busy_o), 320'd0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock_i);
         seen = seen | done_o;
      end
      check("midrst_no_done", 320'(seen), 320'd0);
      check("midrst_idle_busy", 320'(busy_o), 320'd0);

      // start held high across done_o: back-to-back runs with no gap
      @(negedge clock_i);
      start_i      = 1'b1;
      rounds_sel_i = 1'b0;
      state_i      = vb;
      @(posedge clock_i);
      @(negedge clock_i);
      state_i = v6;
      wait_done(0, lat, bcnt);
      check("b2b_first_latency", 320'(lat), 320'(LAT12));
      check("b2b_first_state", state_o, model_perm(vb, 0));
      @(posedge clock_i);
      @(negedge clock_i);
      start_i = 1'b0;
      check("b2b_second_busy", 320'(busy_o), 320'd1);
      wait_done(0, lat, bcnt);
      check("b2b_second_latency", 320'(lat), 320'(LAT12));
      check("b2b_second_state", state_o, model_perm(v6, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/permutation_iter.md
PERMUTATION_ITER -- requirements
Module: permutation_iter

Interface
REQ-001 SHALL have port clock_i, input, 1, single system clock, all state updated on its rising edge.
REQ-002 SHALL have port resetb_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start_i, input, 1, request to run one permutation, sampled only in IDLE.
REQ-004 SHALL have port rounds_sel_i, input, 1, 0 = p12 (12 rounds), 1 = p6 (6 rounds), sampled with start_i.
REQ-005 SHALL have port state_i, input, type_state (5 x 64), permutation input words x0..x4.
REQ-006 SHALL have port state_o, output, type_state, registered permutation state.
REQ-007 SHALL have port busy_o, output, 1, high while rounds are being applied.
REQ-008 SHALL have port done_o, output, 1, one-cycle pulse when state_o holds the final result.

Function
REQ-009 SHALL implement FSM IDLE -> BUSY -> IDLE, with DONE signalled by pulse rather than by a separate state.
REQ-010 IDLE and start_i=1 at an edge: SHALL load state_i into the state register, set round index r = 0 (p12) or 6 (p6), and enter BUSY.
REQ-011 Each BUSY edge: SHALL replace the state with diffusion(substitution(constant_add(state, r))) and increment r.
REQ-012 Round constant: SHALL be c_r = ((0xF - r) << 4) | r, XORed into bits 7:0 of x2, giving 0xF0 at r=0, 0x96 at r=6 and 0x4B at r=11.
REQ-013 Substitution: SHALL be the 5-bit ASCON S-box applied bit-slice-wise across x0..x4, using the team's substitution layer.
REQ-014 Diffusion: SHALL use the team's diffusion layer, with rotations x0(19,28), x1(61,39), x2(1,6), x3(10,17) and x4(7,41).
REQ-015 On the edge applying r = 11: SHALL return to IDLE and assert done_o for exactly the following cycle.
REQ-016 Latency: done_o SHALL be high 12 cycles (p12) or 6 cycles (p6) after the load edge.
REQ-017 busy_o SHALL be high in every cycle the FSM is in BUSY, and low otherwise.
REQ-018 state_o SHALL hold its value in IDLE until the next load.
REQ-019 start_i while BUSY: SHALL be ignored, with no restart and no queuing.
REQ-020 start_i high in the done_o cycle: SHALL be accepted (FSM already IDLE), allowing back-to-back permutations with no gap cycle.
REQ-021 rounds_sel_i changes during BUSY: SHALL have no effect.

Reset
REQ-022 resetb_i=0: SHALL immediately force FSM=IDLE, r=0, state register=0, busy_o=0 and done_o=0, regardless of clock.
REQ-023 Reset mid-operation: SHALL abandon the permutation, with no done_o pulse afterwards.
REQ-024 The first start_i after reset release SHALL be accepted on the first rising edge at which resetb_i is high.

Configuration
REQ-025 Macro PERM_UNROLL2_EN defined: SHALL apply two chained rounds (r, r+1) per BUSY edge and increment r by 2, giving latency 6 (p12) or 3 (p6).
REQ-026 PERM_UNROLL2_EN undefined: SHALL apply one round per edge, per REQ-011 and REQ-016.
REQ-027 The port list, reset behaviour and handshake SHALL be identical in both builds.

Verification
REQ-028 The bench SHALL cover: reset, then p12 on all-zero state_i -> done_o exactly 12 cycles after load, state_o equal to the ASCON reference model p12(0), busy_o high for 12 cycles.
REQ-029 The bench SHALL cover: p6 with state_i = {25f7c341c45f9912, 23b794c540876856, b85451593d679610, 4fafba264a9e49ba, 62b54d5d460aded4} -> done_o after 6 cycles, state_o equal to model p6, first constant 0x96 observed internally.
REQ-030 The bench SHALL cover: start_i pulsed again 3 cycles into a p12 run -> single done_o at cycle 12, result unchanged.
REQ-031 The bench SHALL cover: resetb_i low at cycle 5 of p12 -> state_o=0 and busy_o=0 immediately, no done_o pulse.
REQ-032 The bench SHALL cover: start_i held high across done_o -> second permutation loads that cycle, second done_o 12 cycles later.
REQ-033 The bench SHALL cover: PERM_UNROLL2_EN build repeating REQ-028 and REQ-029 -> identical state_o, latency 6 and 3 respectively.
